// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem request, 2-entry output queue, redirect flush.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0004,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0] out_pc4,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`else
  output logic [31:0] out_pc4
`endif
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic        kill_q;
  fq_entry_t   q_mem [2];
  logic        hd_q;
  logic        tl_q;
  logic [1:0]  cnt_q;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ;
  logic        unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  // Issue only when every outstanding response is sure of a queue slot.
  always_comb begin
    out_valid = !reset && (cnt_q != 2'd0);
    pop       = out_valid && out_ready;
    occ       = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
    issue     = !reset && !redirect_valid && (occ < 3'(QDEPTH));
    push      = inflight_q && !kill_q && !redirect_valid;
    imem_req  = issue;
    imem_addr = reset ? RESET_PC : pc_q;
    out_instr = q_mem[hd_q].instr;
    out_pc    = q_mem[hd_q].pc;
    out_pc4   = q_mem[hd_q].pc + 32'd4;
  end

  // PC, in-flight tracking and queue pointers; reset beats redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      kill_q        <= 1'b0;
      hd_q          <= 1'b0;
      tl_q          <= 1'b0;
      cnt_q         <= 2'd0;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
      kill_q     <= 1'b1;
      hd_q       <= 1'b0;
      tl_q       <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      if (issue) begin
        pc_q          <= pc_q + 32'd4;
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
        kill_q        <= 1'b0;
      end else begin
        inflight_q <= 1'b0;
      end
      if (push) tl_q <= ~tl_q;
      if (pop)  hd_q <= ~hd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Queue storage; the response word lands at the tail.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      q_mem[tl_q] <= '{instr: imem_rdata, pc: inflight_pc_q};
    end
  end

`ifdef FETCH_PERF_EN
  // Delivered-instruction and backpressure-cycle counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (pop)
        perf_fetched <= perf_fetched + 32'd1;
      if (out_valid && !out_ready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency, backpressure,
// redirect, PC wrap and reset-mid-operation.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr;
  logic [31:0] a_rdata, b_rdata;
  logic        a_valid, b_valid;
  logic [31:0] a_instr, b_instr;
  logic [31:0] a_pc, b_pc;
  logic [31:0] a_pc4, b_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] a_pf, a_ps, b_pf, b_ps;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0004)) u_a (
    .clk(clk), .reset(reset),
    .imem_req(a_req), .imem_addr(a_addr),
    .imem_rdata(a_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(a_valid), .out_ready(out_ready),
    .out_instr(a_instr), .out_pc(a_pc),
`ifdef FETCH_PERF_EN
    .out_pc4(a_pc4),
    .perf_fetched(a_pf), .perf_stall(a_ps)
`else
    .out_pc4(a_pc4)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_b (
    .clk(clk), .reset(reset),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_rdata(b_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(b_valid), .out_ready(out_ready),
    .out_instr(b_instr), .out_pc(b_pc),
`ifdef FETCH_PERF_EN
    .out_pc4(b_pc4),
    .perf_fetched(b_pf), .perf_stall(b_ps)
`else
    .out_pc4(b_pc4)
`endif
  );

  // imem model: one-cycle latency, word = address
  logic [31:0] a_ma_q = '0;
  logic [31:0] b_ma_q = '0;
  always @(posedge clk) begin
    if (a_req) a_ma_q <= a_addr;
    if (b_req) b_ma_q <= b_addr;
  end
  assign a_rdata = a_ma_q;
  assign b_rdata = b_ma_q;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  task automatic cyc(input logic rs, input logic rv,
                     input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    reset          = rs;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] pc);
    check({tag, ".v"},  32'(a_valid), 32'd1);
    check({tag, ".pc"}, a_pc, pc);
    check({tag, ".in"}, a_instr, pc);
    check({tag, ".p4"}, a_pc4, pc + 32'd4);
  endtask

  task automatic do_reset(input logic rdy);
    cyc(1'b1, 1'b0, 32'd0, rdy);
    cyc(1'b1, 1'b0, 32'd0, rdy);
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;

    // 1: reset state, latency, streaming, B wraps
    do_reset(1'b1);
    check("rst.req",  32'(a_req), 32'd0);
    check("rst.v",    32'(a_valid), 32'd0);
    check("rst.addr", a_addr, 32'h0000_0004);
    check("rst.addrb", b_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("t1.c1.req",  32'(a_req), 32'd1);
    check("t1.c1.addr", a_addr, 32'h4);
    check("t1.c1.v",    32'(a_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("t1.c2.v", 32'(a_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk_a("t1.c3", 32'h4);
    check("t5.pc0",  b_pc, 32'hFFFF_FFFC);
    check("t5.p40",  b_pc4, 32'h0);
    check("t5.in0",  b_instr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk_a("t1.c4", 32'h8);
    check("t5.pc1", b_pc, 32'h0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk_a("t1.c5", 32'hC);
    check("t5.pc2", b_pc, 32'h4);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk_a("t1.c6", 32'h10);
`ifdef FETCH_PERF_EN
    check("t1.pf", a_pf, 32'd3);
`endif

    // 2: backpressure
    do_reset(1'b0);
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0);
    check("t2.full.v",   32'(a_valid), 32'd1);
    check("t2.full.pc",  a_pc, 32'h4);
    check("t2.full.req", 32'(a_req), 32'd0);
`ifdef FETCH_PERF_EN
    check("t2.ps", a_ps, 32'd5);
`endif
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1);
      chk_a($sformatf("t2.d%0d", i), 32'h4 + 32'(4 * i));
    end

    // 3: redirect while full (holding 8, 12)
    do_reset(1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk_a("t3.c3", 32'h4);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    check("t3.c4.pc", a_pc, 32'h8);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    check("t3.c5.pc",  a_pc, 32'h8);
    check("t3.c5.req", 32'(a_req), 32'd0);
    cyc(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    check("t3.rd.req", 32'(a_req), 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("t3.c7.v",    32'(a_valid), 32'd0);
    check("t3.c7.addr", a_addr, 32'h100);
    check("t3.c7.req",  32'(a_req), 32'd1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("t3.c8.v", 32'(a_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk_a("t3.c9", 32'h100);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk_a("t3.c10", 32'h104);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk_a("t3.c11", 32'h108);

    // 4: redirect in the response cycle of 0x10
    do_reset(1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("t4.c4.addr", a_addr, 32'h10);
    check("t4.c4.req",  32'(a_req), 32'd1);
    cyc(1'b0, 1'b1, 32'h200, 1'b1);
    chk_a("t4.rd.pop", 32'hC);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("t4.c6.v",    32'(a_valid), 32'd0);
    check("t4.c6.addr", a_addr, 32'h200);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("t4.c7.v", 32'(a_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk_a("t4.c8", 32'h200);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk_a("t4.c9", 32'h204);

    // 6: reset while full
    do_reset(1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    check("t6.full.pc", a_pc, 32'h8);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    check("t6.r0.v",   32'(a_valid), 32'd0);
    check("t6.r0.req", 32'(a_req), 32'd0);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    check("t6.r1.v",    32'(a_valid), 32'd0);
    check("t6.r1.req",  32'(a_req), 32'd0);
    check("t6.r1.addr", a_addr, 32'h4);
`ifdef FETCH_PERF_EN
    check("t6.pf", a_pf, 32'd0);
    check("t6.ps", a_ps, 32'd0);
`endif
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("t6.c1.addr", a_addr, 32'h4);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("t6.c2.v", 32'(a_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk_a("t6.c3", 32'h4);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk_a("t6.c4", 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
